fp16_dot_acc: RTL and testbench
===============================

Name: fp16_dot_acc

Overview:
Sequential fp16 dot-product engine that sits directly downstream of the combinational fp16mul and fp16add units and drives them. It consumes a stream of operand pairs (a, b) over a valid/ready handshake. For each pair it multiplies through fp16mul and adds the product into a running fp16 sum through fp16add. After LEN accepted pairs it presents one fp16 result on a valid/ready output port.

Parameters:
LEN, 4, number of operand pairs per dot product; legal range 1..256.
CNT_W, $clog2(LEN+1), width of the beat counter; derived, not overridden.

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  asynchronous active-high reset
i_valid  input  1  operand pair valid
o_ready  output  1  engine can accept a pair this cycle
i_a  input  16  fp16 operand a (sign, 5-bit biased exp, 10-bit mantissa)
i_b  input  16  fp16 operand b
i_rmode  input  1  rounding mode, passed to fp16mul/fp16add for this beat
o_valid  output  1  dot-product result valid
i_ready  input  1  consumer accepts result
o_res  output  16  fp16 dot-product result

Behaviour:
- Reset values (async on rst=1):
  - o_valid=0, o_res=16'h0000, o_ready=0 while rst is high.
  - Accumulator=16'h0000, counter=0, state=ACC.
- States:
  - ACC: o_ready=1.
  - DONE: o_ready=0, o_valid=1.
  - DRAIN: exists only with the optional feature.
- Beat accept = i_valid && o_ready.
- On accept:
  - prod = fp16mul(i_a, i_b, i_rmode).
  - acc <= fp16add(acc, prod, i_rmode).
  - counter <= counter+1.
- Accept with counter==LEN-1 (no pipe): o_res <= the fp16add output, o_valid <= 1, state -> DONE. Latency is 1 cycle from the last accept edge to o_valid.
- Result in DONE:
  - o_res is held stable and o_valid stays 1 until i_ready=1.
  - On the cycle with o_valid && i_ready: o_valid <= 0, acc <= 16'h0000, counter <= 0, state -> ACC.
  - o_ready rises the cycle after the handshake. No overlap of result and next vector.
- The accumulator starts each vector at +0. Signed-zero, Inf and NaN behaviour is inherited unchanged from fp16mul/fp16add; no flags are produced.
- i_a, i_b and i_rmode are only sampled on accept. Values presented with i_valid=0 have no effect.
- LEN=1: the first accept goes straight to DONE.
- rst mid-vector or mid-DONE: the partial sum and any pending result are discarded, and o_valid drops immediately.
- Counter never exceeds LEN-1 in ACC; wrap-around is by explicit clear only.

Optional Feature:
Macro FP16_DOT_PIPE_EN.
- Defined:
  - A register stage is inserted between fp16mul and fp16add, holding prod, the beat's rmode and a last flag.
  - The add happens one cycle after accept. o_ready stays 1 in ACC, so back-to-back beats are allowed.
  - Accepting the last beat moves the state to DRAIN with o_ready=0. The next cycle performs the final add, sets o_valid=1 and moves to DONE.
  - Latency is 2 cycles from the last accept to o_valid.
- Undefined: single-stage behaviour exactly as above, with no DRAIN state.

Decomposition:
- Shared package fp16_pkg holds:
  - field widths: EXP_W=5, MANT_W=10.
  - constants FP16_POS_ZERO=16'h0000, FP16_POS_INF=16'h7C00.
  - the state encoding: ACC, DRAIN, DONE.
- fp16mul and fp16add are instantiated unchanged as leaf cells.
- One natural sub-module: fp16_dot_ctrl, holding the FSM, counter and handshake logic. It emits an acc-enable, an acc-clear and a result-load; the datapath stays in fp16_dot_acc.

Test Plan:
- Result checking uses the team tolerance: |diff of bits [14:0]| < 5, matching sign, and exact class for zero/Inf.
- LEN=4, pairs (3C00,4000),(4000,4000),(4200,3C00),(3800,4000), i_ready=1 -> o_res=4900 (10.0), o_valid one cycle after the 4th accept (two with FP16_DOT_PIPE_EN).
- Mixed signs, LEN=4: (BC00,4000),(3C00,3C00)×3 -> 3C00 (1.0).
- Overflow/special, LEN=4: (7800,7800) then three (3C00,3C00) -> 7C00; separately (7C00,3C00) first -> 7C00.
- Backpressure: after the result, hold i_ready=0 for 3 cycles -> o_valid=1, o_res stable, o_ready=0, and i_valid pulses ignored. i_ready=1 -> o_ready=1 next cycle.
- Reset mid-vector: accept 2 beats, pulse rst, then 4×(3C00,3C00) -> o_res=4400 (4.0) with no stale contribution.
- Gapped input: 4×(4000,3800) with i_valid low on alternate cycles -> o_res=4400; counter advances only on accept.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared fp16 field widths, constants, dot-engine state encoding and the
// normalise/round/pack helper used by fp16mul and fp16add.
package fp16_pkg;

    localparam int unsigned EXP_W  = 5;
    localparam int unsigned MANT_W = 10;

    localparam logic [15:0]      FP16_POS_ZERO = 16'h0000;
    localparam logic [15:0]      FP16_POS_INF  = 16'h7C00;
    localparam logic [15:0]      FP16_QNAN     = 16'h7E00;
    localparam logic [EXP_W-1:0] EXP_MAX       = 5'h1F;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } dot_state_e;

    // Value represented is (sig_in / 2^21) * 2^(exp_in - 15); rmode 0 = nearest-even, 1 = toward zero.
    function automatic logic [15:0] fp16_round_pack(
        input logic               sign,
        input logic signed [9:0]  exp_in,
        input logic [21:0]        sig_in,
        input logic               rmode
    );
        logic [21:0]       sig;
        logic signed [9:0] e;
        logic [4:0]        lz;
        logic              sticky;
        logic              rnd;
        logic [14:0]       mag;
        int                dn;

        sig    = sig_in;
        e      = exp_in;
        lz     = '0;
        sticky = 1'b0;
        if (sig == '0)
            return {sign, 15'd0};

        for (int unsigned i = 0; i < 22; i++)
            if (sig[i]) lz = 5'(21 - i);
        sig = sig << lz;
        e   = e - $signed({5'd0, lz});

        // Underflow: denormalise down to the subnormal exponent, folding lost bits into sticky.
        if (e < 10'sd1) begin
            dn = 1 - int'(e);
            if (dn > 22) begin
                sticky = |sig;
                sig    = '0;
            end else begin
                sticky = |(sig & ((22'd1 << dn) - 22'd1));
                sig    = sig >> dn;
            end
            e = 10'sd1;
        end

        if (e > 10'sd30)
            return {sign, rmode ? 15'h7BFF : FP16_POS_INF[14:0]};

        mag = {(sig[21] ? e[4:0] : 5'd0), sig[20:11]};
        rnd = !rmode && sig[10] && (sig[11] || (|sig[9:0]) || sticky);
        return {sign, mag + 15'(rnd)};
    endfunction

endpackage

// File: rtl/fp16_dot_ctrl.sv
// Beat counter, handshakes and ACC/DRAIN/DONE sequencing for fp16_dot_acc.
// DRAIN is only entered when FP16_DOT_PIPE_EN is defined.
module fp16_dot_ctrl
    import fp16_pkg::*;
#(
    parameter int unsigned LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    output logic o_ready,
    output logic o_valid,
    input  logic i_ready,
    output logic o_acc_en,
    output logic o_acc_clr,
    output logic o_res_load
);

    localparam int unsigned CNT_W = $clog2(LEN + 1);

    dot_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept, w_last;

    assign w_accept   = i_valid && o_ready;
    assign w_last     = (r_cnt == CNT_W'(LEN - 1));
    assign o_acc_en   = w_accept;
    assign o_acc_clr  = o_valid && i_ready;
    assign o_res_load = w_accept && w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ACC;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (o_acc_clr)
            r_cnt <= '0;
        else if (w_accept)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ACC: begin
                if (w_accept && w_last) begin
`ifdef FP16_DOT_PIPE_EN
                    w_state_nxt = DRAIN;
`else
                    w_state_nxt = DONE;
`endif
                end
            end
            DRAIN:   w_state_nxt = DONE;
            DONE:    if (i_ready) w_state_nxt = ACC;
            default: w_state_nxt = ACC;
        endcase
    end

    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        unique case (r_state)
            ACC:     o_ready = !rst;
            DRAIN:   o_ready = 1'b0;
            DONE:    o_valid = 1'b1;
            default: o_ready = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp16add.sv
// Combinational fp16 adder: magnitude-ordered align, add/subtract, shared round/pack.
module fp16add
    import fp16_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_rmode,
    output logic [15:0] o_y
);

    logic [14:0]       w_a_mag, w_b_mag, w_small;
    logic [15:0]       w_big;
    logic              w_swap, w_eff_sub;
    logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic [EXP_W-1:0]  w_e_big, w_e_small, w_dexp;
    logic [21:0]       w_m_big, w_m_small, w_m_align, w_sum;
    logic              w_lost;
    logic signed [9:0] w_exp;

    assign w_a_mag   = i_a[14:0];
    assign w_b_mag   = i_b[14:0];
    assign w_swap    = (w_b_mag > w_a_mag);
    assign w_big     = w_swap ? i_b : i_a;
    assign w_small   = w_swap ? w_a_mag : w_b_mag;
    assign w_eff_sub = i_a[15] ^ i_b[15];

    assign w_e_big   = (w_big[14:MANT_W] == '0) ? EXP_W'(1) : w_big[14:MANT_W];
    assign w_e_small = (w_small[14:MANT_W] == '0) ? EXP_W'(1) : w_small[14:MANT_W];
    assign w_m_big   = {1'b0, (w_big[14:MANT_W] != '0), w_big[MANT_W-1:0], 10'd0};
    assign w_m_small = {1'b0, (w_small[14:MANT_W] != '0), w_small[MANT_W-1:0], 10'd0};
    assign w_dexp    = w_e_big - w_e_small;

    // Shifted-out bits collapse into the LSB so subtraction still rounds correctly.
    always_comb begin
        if (w_dexp > 5'd21) begin
            w_m_align = '0;
            w_lost    = |w_m_small;
        end else begin
            w_m_align = w_m_small >> w_dexp;
            w_lost    = |(w_m_small & ((22'd1 << w_dexp) - 22'd1));
        end
    end

    assign w_sum = w_eff_sub ? (w_m_big - (w_m_align | {21'd0, w_lost}))
                             : (w_m_big + (w_m_align | {21'd0, w_lost}));
    assign w_exp = $signed({5'd0, w_e_big}) + 10'sd1;

    assign w_a_inf = (i_a[14:MANT_W] == EXP_MAX) && (i_a[MANT_W-1:0] == '0);
    assign w_b_inf = (i_b[14:MANT_W] == EXP_MAX) && (i_b[MANT_W-1:0] == '0);
    assign w_a_nan = (i_a[14:MANT_W] == EXP_MAX) && (i_a[MANT_W-1:0] != '0);
    assign w_b_nan = (i_b[14:MANT_W] == EXP_MAX) && (i_b[MANT_W-1:0] != '0);

    always_comb begin
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && w_eff_sub))
            o_y = FP16_QNAN;
        else if (w_a_inf)
            o_y = i_a;
        else if (w_b_inf)
            o_y = i_b;
        else if ((w_a_mag == '0) && (w_b_mag == '0))
            o_y = {i_a[15] & i_b[15], 15'd0};
        else if (w_sum == '0)
            o_y = FP16_POS_ZERO;
        else
            o_y = fp16_round_pack(w_big[15], w_exp, w_sum, i_rmode);
    end

endmodule

// File: rtl/fp16mul.sv
// Combinational fp16 multiplier with subnormal, Inf and NaN handling.
module fp16mul
    import fp16_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_rmode,
    output logic [15:0] o_y
);

    logic              w_sign;
    logic [EXP_W-1:0]  w_ea, w_eb, w_ea_eff, w_eb_eff;
    logic [MANT_W:0]   w_ma, w_mb;
    logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [21:0]       w_prod;
    logic signed [9:0] w_exp;

    assign w_sign   = i_a[15] ^ i_b[15];
    assign w_ea     = i_a[14:MANT_W];
    assign w_eb     = i_b[14:MANT_W];
    assign w_ea_eff = (w_ea == '0) ? EXP_W'(1) : w_ea;
    assign w_eb_eff = (w_eb == '0) ? EXP_W'(1) : w_eb;
    assign w_ma     = {(w_ea != '0), i_a[MANT_W-1:0]};
    assign w_mb     = {(w_eb != '0), i_b[MANT_W-1:0]};

    assign w_a_inf  = (w_ea == EXP_MAX) && (i_a[MANT_W-1:0] == '0);
    assign w_b_inf  = (w_eb == EXP_MAX) && (i_b[MANT_W-1:0] == '0);
    assign w_a_nan  = (w_ea == EXP_MAX) && (i_a[MANT_W-1:0] != '0);
    assign w_b_nan  = (w_eb == EXP_MAX) && (i_b[MANT_W-1:0] != '0);
    assign w_a_zero = (i_a[14:0] == '0);
    assign w_b_zero = (i_b[14:0] == '0);

    assign w_prod = w_ma * w_mb;
    assign w_exp  = $signed({5'd0, w_ea_eff}) + $signed({5'd0, w_eb_eff}) - 10'sd14;

    always_comb begin
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
            o_y = FP16_QNAN;
        else if (w_a_inf || w_b_inf)
            o_y = {w_sign, FP16_POS_INF[14:0]};
        else if (w_a_zero || w_b_zero)
            o_y = {w_sign, 15'd0};
        else
            o_y = fp16_round_pack(w_sign, w_exp, w_prod, i_rmode);
    end

endmodule

// File: rtl/fp16_dot_acc.sv
// fp16 dot-product engine: fp16mul -> fp16add running sum over LEN pairs.
// FP16_DOT_PIPE_EN adds a product register between multiplier and adder.
module fp16_dot_acc
    import fp16_pkg::*;
#(
    parameter int unsigned LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_rmode,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_res
);

    logic        w_acc_en, w_acc_clr, w_res_load;
    logic        w_add_en, w_res_en;
    logic [15:0] w_prod, w_sum;
    logic [15:0] r_acc, r_res;

    fp16_dot_ctrl #(.LEN(LEN)) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_acc_en   (w_acc_en),
        .o_acc_clr  (w_acc_clr),
        .o_res_load (w_res_load)
    );

    fp16mul u_mul (
        .i_a     (i_a),
        .i_b     (i_b),
        .i_rmode (i_rmode),
        .o_y     (w_prod)
    );

`ifdef FP16_DOT_PIPE_EN
    logic [15:0] r_prod;
    logic        r_prmode, r_plast, r_pvld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod   <= FP16_POS_ZERO;
            r_prmode <= 1'b0;
            r_plast  <= 1'b0;
            r_pvld   <= 1'b0;
        end else begin
            r_pvld <= w_acc_en;
            if (w_acc_en) begin
                r_prod   <= w_prod;
                r_prmode <= i_rmode;
                r_plast  <= w_res_load;
            end
        end
    end

    fp16add u_add (
        .i_a     (r_acc),
        .i_b     (r_prod),
        .i_rmode (r_prmode),
        .o_y     (w_sum)
    );

    assign w_add_en = r_pvld;
    assign w_res_en = r_pvld && r_plast;
`else
    fp16add u_add (
        .i_a     (r_acc),
        .i_b     (w_prod),
        .i_rmode (i_rmode),
        .o_y     (w_sum)
    );

    assign w_add_en = w_acc_en;
    assign w_res_en = w_res_load;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_acc <= FP16_POS_ZERO;
        else if (w_acc_clr)
            r_acc <= FP16_POS_ZERO;
        else if (w_add_en)
            r_acc <= w_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_res <= FP16_POS_ZERO;
        else if (w_res_en)
            r_res <= w_sum;
    end

    assign o_res = r_res;

endmodule

// File: tb/tb_fp16_dot_acc.sv
// Directed self-checking bench for fp16_dot_acc (LEN=4); latency follows FP16_DOT_PIPE_EN.
module tb_fp16_dot_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic        i_rmode;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_res;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    fp16_dot_acc #(.LEN(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_rmode (i_rmode),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_res   (o_res)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Zero/Inf must match exactly; finite results within 4 ulp with matching sign.
    task automatic check_res(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        logic ok;
        int   d;
        if (exp[14:0] == 15'd0 || exp[14:10] == 5'h1F) begin
            ok = (obs === exp);
        end else begin
            d  = int'(obs[14:0]) - int'(exp[14:0]);
            if (d < 0) d = -d;
            ok = (obs[15] === exp[15]) && (obs[14:10] != 5'h1F) && (d < 5);
        end
        n_cmp++;
        assert (ok === 1'b1) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int unsigned waited = 0;
        i_a     = a;
        i_b     = b;
        i_valid = 1'b1;
        while (o_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check("accept_ready", {15'd0, o_ready}, 16'd1);
        tick();
        i_valid = 1'b0;
        i_a     = 16'h7C00;
        i_b     = 16'h7C00;
    endtask

    task automatic feed(input logic [63:0] va, input logic [63:0] vb, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send(va[16*(3-i) +: 16], vb[16*(3-i) +: 16]);
            if (gap && i < 3) tick();
        end
    endtask

    // Called at #1 after the edge that accepted the last beat.
    task automatic expect_result(input string tag, input logic [15:0] exp);
`ifdef FP16_DOT_PIPE_EN
        check({tag, "_drain_valid"}, {15'd0, o_valid}, 16'd0);
        check({tag, "_drain_ready"}, {15'd0, o_ready}, 16'd0);
        tick();
`endif
        check({tag, "_valid"}, {15'd0, o_valid}, 16'd1);
        check({tag, "_ready_low"}, {15'd0, o_ready}, 16'd0);
        check_res({tag, "_res"}, o_res, exp);
    endtask

    task automatic handshake(input string tag);
        i_ready = 1'b1;
        tick();
        check({tag, "_hs_valid"}, {15'd0, o_valid}, 16'd0);
        check({tag, "_hs_ready"}, {15'd0, o_ready}, 16'd1);
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_a     = 16'h0000;
        i_b     = 16'h0000;
        i_rmode = 1'b0;
        i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {15'd0, o_valid}, 16'd0);
        check("rst_res", o_res, 16'h0000);
        check("rst_ready", {15'd0, o_ready}, 16'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {15'd0, o_ready}, 16'd1);
        tick();

        // 1*2 + 2*2 + 3*1 + 0.5*2 = 10.0
        feed(64'h3C00_4000_4200_3800, 64'h4000_4000_3C00_4000, 1'b0);
        expect_result("dot10", 16'h4900);
        handshake("dot10");

        // -2 + 1 + 1 + 1 = 1.0
        feed(64'hBC00_3C00_3C00_3C00, 64'h4000_3C00_3C00_3C00, 1'b0);
        expect_result("mixed", 16'h3C00);
        handshake("mixed");

        // 32768^2 overflows to +Inf and stays there
        feed(64'h7800_3C00_3C00_3C00, 64'h7800_3C00_3C00_3C00, 1'b0);
        expect_result("ovf", 16'h7C00);
        handshake("ovf");

        feed(64'h7C00_3C00_3C00_3C00, 64'h3C00_3C00_3C00_3C00, 1'b0);
        expect_result("inf_in", 16'h7C00);
        handshake("inf_in");

        // Backpressure: result held, input pulses ignored
        i_ready = 1'b0;
        feed(64'h3C00_4000_4200_3800, 64'h4000_4000_3C00_4000, 1'b0);
        expect_result("bp", 16'h4900);
        for (int k = 0; k < 3; k++) begin
            i_valid = (k != 1);
            i_a     = 16'h4000;
            i_b     = 16'h4000;
            tick();
            check("bp_hold_valid", {15'd0, o_valid}, 16'd1);
            check("bp_hold_res", o_res, 16'h4900);
            check("bp_hold_ready", {15'd0, o_ready}, 16'd0);
        end
        i_valid = 1'b0;
        handshake("bp");
        feed(64'h3C00_3C00_3C00_3C00, 64'h3C00_3C00_3C00_3C00, 1'b0);
        expect_result("after_bp", 16'h4400);
        handshake("after_bp");

        // Reset mid-vector discards the partial sum
        send(16'h4000, 16'h4000);
        send(16'h4000, 16'h4000);
        rst = 1'b1;
        #2;
        check("midrst_ready", {15'd0, o_ready}, 16'd0);
        check("midrst_valid", {15'd0, o_valid}, 16'd0);
        rst = 1'b0;
        tick();
        feed(64'h3C00_3C00_3C00_3C00, 64'h3C00_3C00_3C00_3C00, 1'b0);
        expect_result("midrst", 16'h4400);
        handshake("midrst");

        // Gapped input: 4 * (2 * 0.5) = 4.0
        feed(64'h4000_4000_4000_4000, 64'h3800_3800_3800_3800, 1'b1);
        expect_result("gap", 16'h4400);
        handshake("gap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
